// File: rtl/uart_tlul_tx_sequencer.sv
// uart_tlul_tx_sequencer
//   TL-UL host that brings up the UART and then streams bytes into it. After reset
//   it writes CTRL once (NCO + TX enable). It then drains an internal byte FIFO.
//   For each byte it polls STATUS.TXFULL and writes WDATA only when the UART has room.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   byte_valid_i/_data_i/byte_ready_o   byte push interface (valid/ready)
//   busy_o            work pending (not IDLE or FIFO non-empty), registered
//   init_done_o       CTRL write acknowledged without error
//   err_o             sticky, set by any d_error
//   sent_cnt_o        acknowledged WDATA writes, wrapping 16-bit count
//   tl_a_*            TL-UL A channel (registered, stable while valid)
//   tl_d_*            TL-UL D channel (ready only while awaiting a response)
module uart_tlul_tx_sequencer #(
    parameter logic [31:0] UART_BASE  = 32'h2000_0000,
    parameter logic [15:0] NCO_VAL    = 16'd1208,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [7:0]  SOURCE_ID  = 8'h0,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        busy_o,
    output logic        init_done_o,
    output logic        err_o,
    output logic [15:0] sent_cnt_o,
    output logic        tl_a_valid_o,
    output logic [2:0]  tl_a_opcode_o,
    output logic [1:0]  tl_a_size_o,
    output logic [7:0]  tl_a_source_o,
    output logic [31:0] tl_a_address_o,
    output logic [3:0]  tl_a_mask_o,
    output logic [31:0] tl_a_data_o,
    input  logic        tl_a_ready_i,
    input  logic        tl_d_valid_i,
    input  logic [31:0] tl_d_data_i,
    input  logic        tl_d_error_i,
    output logic        tl_d_ready_o
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(POLL_GAP + 2);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_INIT = GW'(POLL_GAP);
    localparam logic [2:0] OP_PUT = 3'd0;
    localparam logic [2:0] OP_GET = 3'd4;

    typedef enum logic [3:0] {
        S_INIT_REQ, S_INIT_RSP, S_IDLE, S_POLL_REQ, S_POLL_RSP,
        S_GAP, S_WR_REQ, S_WR_RSP, S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic [7:0]      head;
    logic            a_valid_q, a_valid_d;
    logic [2:0]      a_opcode_q, a_opcode_d;
    logic [31:0]     a_address_q, a_address_d;
    logic [31:0]     a_data_q, a_data_d;
    logic            init_done_q, init_done_d;
    logic            err_q, err_d;
    logic [15:0]     sent_q, sent_d;
    logic            busy_q, busy_d;
    logic            a_hs;
    logic            unused_d_data;

    assign unused_d_data = ^tl_d_data_i[31:1];

    assign a_hs = a_valid_q & tl_a_ready_i;
    assign head = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign byte_ready_o = (count_q != FULL_CNT) | pop;
    assign push         = byte_valid_i & byte_ready_o;

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        pop         = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;
        sent_d      = sent_q;
        unique case (state_q)
            S_INIT_REQ: if (a_hs) state_d = S_INIT_RSP;
            S_INIT_RSP: begin
                if (tl_d_valid_i) begin
                    if (tl_d_error_i) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_IDLE:     if (count_q != '0) state_d = S_POLL_REQ;
            S_POLL_REQ: if (a_hs) state_d = S_POLL_RSP;
            S_POLL_RSP: begin
                if (tl_d_valid_i) begin
                    if (tl_d_error_i) begin
                        err_d   = 1'b1;
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end else if (tl_d_data_i[0]) begin
                        gap_d   = GAP_INIT;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_WR_REQ;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_POLL_REQ;
                else             gap_d   = gap_q - 1'b1;
            end
            S_WR_REQ:   if (a_hs) state_d = S_WR_RSP;
            S_WR_RSP: begin
                if (tl_d_valid_i) begin
                    pop = 1'b1;
                    if (tl_d_error_i) err_d  = 1'b1;
                    else              sent_d = sent_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HALT:     ;
            default:    state_d = S_INIT_REQ;
        endcase
    end

    // A-channel fields are loaded from the next state, so valid rises on entry to a
    // *_REQ state and drops on the edge that leaves it (the handshake edge).
    always_comb begin
        a_valid_d   = 1'b0;
        a_opcode_d  = OP_PUT;
        a_address_d = '0;
        a_data_d    = '0;
        unique case (state_d)
            S_INIT_REQ: begin
                a_valid_d   = 1'b1;
                a_address_d = UART_BASE + 32'h10;
                a_data_d    = {NCO_VAL, 16'h0001};
            end
            S_POLL_REQ: begin
                a_valid_d   = 1'b1;
                a_opcode_d  = OP_GET;
                a_address_d = UART_BASE + 32'h14;
            end
            S_WR_REQ: begin
                a_valid_d   = 1'b1;
                a_address_d = UART_BASE + 32'h1c;
                a_data_d    = {24'h0, head};
            end
            default: ;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
        busy_d = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_INIT_REQ;
            gap_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            a_valid_q   <= 1'b0;
            a_opcode_q  <= '0;
            a_address_q <= '0;
            a_data_q    <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            sent_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            count_q     <= count_d;
            a_valid_q   <= a_valid_d;
            a_opcode_q  <= a_opcode_d;
            a_address_q <= a_address_d;
            a_data_q    <= a_data_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            sent_q      <= sent_d;
            busy_q      <= busy_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= byte_data_i;
    end

    assign busy_o         = busy_q;
    assign init_done_o    = init_done_q;
    assign err_o          = err_q;
    assign sent_cnt_o     = sent_q;
    assign tl_a_valid_o   = a_valid_q;
    assign tl_a_opcode_o  = a_opcode_q;
    assign tl_a_size_o    = 2'd2;
    assign tl_a_source_o  = SOURCE_ID;
    assign tl_a_address_o = a_address_q;
    assign tl_a_mask_o    = 4'hF;
    assign tl_a_data_o    = a_data_q;
    assign tl_d_ready_o   = (state_q == S_INIT_RSP) || (state_q == S_POLL_RSP) ||
                            (state_q == S_WR_RSP);

endmodule

// File: tb/tb_uart_tlul_tx_sequencer.sv
// Testbench for uart_tlul_tx_sequencer: behavioural TL-UL slave, scoreboard of
// required A-channel requests, vector table for per-byte scenarios.
module tb_uart_tlul_tx_sequencer;

    localparam logic [31:0] BASE     = 32'h2000_0000;
    localparam logic [2:0]  OP_PUT   = 3'd0;
    localparam logic [2:0]  OP_GET   = 3'd4;
    localparam int          POLL_GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = '0;
    logic        byte_ready_o, busy_o, init_done_o, err_o;
    logic [15:0] sent_cnt_o;
    logic        tl_a_valid_o;
    logic [2:0]  tl_a_opcode_o;
    logic [1:0]  tl_a_size_o;
    logic [7:0]  tl_a_source_o;
    logic [31:0] tl_a_address_o;
    logic [3:0]  tl_a_mask_o;
    logic [31:0] tl_a_data_o;
    logic        tl_a_ready_i = 1'b1;
    logic        tl_d_valid_i = 1'b0;
    logic [31:0] tl_d_data_i = '0;
    logic        tl_d_error_i = 1'b0;
    logic        tl_d_ready_o;

    uart_tlul_tx_sequencer #(
        .UART_BASE(BASE), .NCO_VAL(16'd1208), .FIFO_DEPTH(8),
        .SOURCE_ID(8'h00), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
        .busy_o(busy_o), .init_done_o(init_done_o), .err_o(err_o), .sent_cnt_o(sent_cnt_o),
        .tl_a_valid_o(tl_a_valid_o), .tl_a_opcode_o(tl_a_opcode_o), .tl_a_size_o(tl_a_size_o),
        .tl_a_source_o(tl_a_source_o), .tl_a_address_o(tl_a_address_o),
        .tl_a_mask_o(tl_a_mask_o), .tl_a_data_o(tl_a_data_o), .tl_a_ready_i(tl_a_ready_i),
        .tl_d_valid_i(tl_d_valid_i), .tl_d_data_i(tl_d_data_i), .tl_d_error_i(tl_d_error_i),
        .tl_d_ready_o(tl_d_ready_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [7:0]  data;
        int          n_full;
        int          stall;
        logic [15:0] exp_sent;
    } vec_t;

    txn_t        exp_q[$];
    logic [31:0] status_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          hold_full = 0;
    bit          ctrl_err = 0;
    int          stall_left = 0;
    bit          stalling = 0;
    logic [31:0] stall_addr, stall_data;
    bit          hs_pend = 0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    int          idle_run = 0;
    bit          gap_check = 0;
    int          holdfull_gets = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.op = op; t.addr = addr; t.data = data;
        return t;
    endfunction

    task automatic exp_init();
        exp_q.push_back(mk(OP_PUT, 32'h2000_0010, 32'h04B8_0001));
    endtask

    // n_full STATUS reads answering TXFULL=1, then one with room, then the WDATA write.
    task automatic exp_byte(input logic [7:0] b, input int n_full);
        for (int i = 0; i <= n_full; i++) begin
            exp_q.push_back(mk(OP_GET, 32'h2000_0014, 32'h0));
            status_q.push_back((i < n_full) ? 32'h1 : 32'h0);
        end
        exp_q.push_back(mk(OP_PUT, 32'h2000_001c, {24'h0, b}));
    endtask

    // Called at a negedge when a handshake will complete on the next posedge.
    task automatic record_req();
        txn_t e;
        rsp_data = '0;
        rsp_err  = 1'b0;
        check("a_size", 32'(tl_a_size_o), 32'd2);
        check("a_mask", 32'(tl_a_mask_o), 32'hF);
        check("a_source", 32'(tl_a_source_o), 32'h0);
        if (hold_full && tl_a_opcode_o == OP_GET) begin
            rsp_data = 32'h1;
            holdfull_gets++;
            gap_check = 1;
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_request: got op %0d addr %h data %h required none",
                     tl_a_opcode_o, tl_a_address_o, tl_a_data_o);
        end else begin
            e = exp_q.pop_front();
            check("a_opcode", 32'(tl_a_opcode_o), 32'(e.op));
            check("a_address", tl_a_address_o, e.addr);
            check("a_data", tl_a_data_o, e.data);
            if (tl_a_opcode_o == OP_GET) begin
                rsp_data = (status_q.size() > 0) ? status_q.pop_front() : 32'h0;
                if (rsp_data[0]) gap_check = 1;
            end else if (tl_a_address_o == 32'h2000_0010 && ctrl_err) begin
                rsp_err  = 1'b1;
                ctrl_err = 0;
            end
        end
    endtask

    // One clock of the slave model; returns in the negedge context.
    task automatic step();
        @(negedge clk);
        tl_d_valid_i = 1'b0;
        tl_d_error_i = 1'b0;
        tl_d_data_i  = '0;
        if (hs_pend) begin
            check("d_ready in response state", 32'(tl_d_ready_o), 32'd1);
            tl_d_valid_i = 1'b1;
            tl_d_data_i  = rsp_data;
            tl_d_error_i = rsp_err;
            hs_pend      = 0;
            idle_run     = 0;
        end else if (!tl_a_valid_o) begin
            idle_run++;
        end
        tl_a_ready_i = 1'b1;
        if (tl_a_valid_o) begin
            if (gap_check) begin
                check("poll gap idle cycles >= POLL_GAP", 32'(idle_run >= POLL_GAP), 32'd1);
                gap_check = 0;
            end
            if (stall_left > 0 && tl_a_address_o == 32'h2000_001c) begin
                if (!stalling) begin
                    stalling   = 1;
                    stall_addr = tl_a_address_o;
                    stall_data = tl_a_data_o;
                end else begin
                    check("stalled address stable", tl_a_address_o, stall_addr);
                    check("stalled data stable", tl_a_data_o, stall_data);
                end
                tl_a_ready_i = 1'b0;
                stall_left--;
            end else begin
                if (stalling) begin
                    check("stalled address stable", tl_a_address_o, stall_addr);
                    check("stalled data stable", tl_a_data_o, stall_data);
                    stalling = 0;
                end
                hs_pend = 1;
                record_req();
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hs_pend = 0; gap_check = 0; stalling = 0; stall_left = 0; hold_full = 0;
        exp_q.delete();
        status_q.delete();
        byte_valid_i = 1'b0;
        step();
        check("reset byte_ready", 32'(byte_ready_o), 32'd1);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset init_done", 32'(init_done_o), 32'd0);
        check("reset err", 32'(err_o), 32'd0);
        check("reset sent_cnt", 32'(sent_cnt_o), 32'd0);
        check("reset a_valid", 32'(tl_a_valid_o), 32'd0);
        check("reset a_address", tl_a_address_o, 32'h0);
        check("reset d_ready", 32'(tl_d_ready_o), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic wait_init(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (init_done_o || err_o) break;
        end
        if (i == budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got timeout after %0d cycles required CTRL response", name, budget);
        end
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (exp_q.size() == 0 && !hs_pend && !tl_d_valid_i && !busy_o) break;
        end
        if (i == budget) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got timeout with %0d requests outstanding required idle", name, exp_q.size());
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        step();
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        step();
        byte_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{data: 8'h41, n_full: 3, stall: 0,  exp_sent: 16'd3};
        vecs[1] = '{data: 8'h42, n_full: 0, stall: 10, exp_sent: 16'd4};
        vecs[2] = '{data: 8'h00, n_full: 1, stall: 0,  exp_sent: 16'd5};
        vecs[3] = '{data: 8'hFF, n_full: 0, stall: 3,  exp_sent: 16'd6};

        @(negedge clk);
        do_reset();
        exp_init();
        wait_init("init", 50);
        check("init_done after CTRL ack", 32'(init_done_o), 32'd1);
        check("err after CTRL ack", 32'(err_o), 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("busy with empty FIFO", 32'(busy_o), 32'd0);
        check("no pending requests", 32'(exp_q.size()), 32'd0);

        // 'H','i' pushed back-to-back
        exp_byte(8'h48, 0);
        exp_byte(8'h69, 0);
        step();
        byte_valid_i = 1'b1; byte_data_i = 8'h48;
        step();
        byte_data_i = 8'h69;
        step();
        byte_valid_i = 1'b0;
        run_until_idle("Hi", 200);
        check("sent_cnt after Hi", 32'(sent_cnt_o), 32'd2);
        check("busy after Hi", 32'(busy_o), 32'd0);

        for (int unsigned v = 0; v < 4; v++) begin
            exp_byte(vecs[v].data, vecs[v].n_full);
            stall_left = vecs[v].stall;
            push_byte(vecs[v].data);
            run_until_idle("vector", 300);
            check("vector sent_cnt", 32'(sent_cnt_o), 32'(vecs[v].exp_sent));
            check("vector busy", 32'(busy_o), 32'd0);
            check("vector err", 32'(err_o), 32'd0);
        end

        // nine back-to-back pushes while the UART reports TXFULL
        hold_full = 1;
        for (int k = 0; k < 9; k++) begin
            step();
            byte_valid_i = 1'b1;
            byte_data_i  = 8'(8'h10 + k);
            check("byte_ready during fill", 32'(byte_ready_o), (k < 8) ? 32'd1 : 32'd0);
        end
        step();
        byte_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("byte_ready when full", 32'(byte_ready_o), 32'd0);
        for (int k = 0; k < 8; k++) exp_byte(8'(8'h10 + k), 0);
        hold_full = 0;
        run_until_idle("fill-drain", 600);
        check("sent_cnt after drain", 32'(sent_cnt_o), 32'd14);
        check("byte_ready after drain", 32'(byte_ready_o), 32'd1);

        // CTRL response with d_error: halt
        do_reset();
        ctrl_err = 1;
        exp_init();
        wait_init("init with error", 50);
        check("err after CTRL error", 32'(err_o), 32'd1);
        check("init_done after CTRL error", 32'(init_done_o), 32'd0);
        push_byte(8'h55);
        for (int i = 0; i < 30; i++) step();
        check("busy in halt", 32'(busy_o), 32'd1);
        check("d_ready in halt", 32'(tl_d_ready_o), 32'd0);
        check("byte_ready in halt", 32'(byte_ready_o), 32'd1);

        // reset during polling
        do_reset();
        ctrl_err = 0;
        exp_init();
        wait_init("re-init", 50);
        check("init_done after re-init", 32'(init_done_o), 32'd1);
        hold_full = 1;
        holdfull_gets = 0;
        push_byte(8'h77);
        begin
            int i;
            for (i = 0; i < 200; i++) begin
                if (holdfull_gets >= 2) break;
                step();
            end
            if (i == 200) begin
                n_cmp++; n_bad++;
                $display("FAIL poll wait: got %0d polls required 2", holdfull_gets);
            end
        end
        do_reset();
        exp_init();
        wait_init("init after mid-poll reset", 50);
        check("init_done after mid-poll reset", 32'(init_done_o), 32'd1);
        for (int i = 0; i < 20; i++) step();
        check("busy after mid-poll reset", 32'(busy_o), 32'd0);
        check("sent_cnt after mid-poll reset", 32'(sent_cnt_o), 32'd0);
        check("no pending after mid-poll reset", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tlul_tx_sequencer.md
Name: uart_tlul_tx_sequencer

Overview:
TL-UL host-side controller that brings up the OpenTitan UART and streams bytes into it without CPU involvement. After reset it writes CTRL once to set the NCO and TX enable. It then drains an internal byte FIFO. For each byte it polls STATUS.TXFULL and writes WDATA only when the UART TX FIFO has room. It sits beside the Ibex data port as a boot/console traffic source; a separate crossbar or arbiter merges its TL port with the Ibex data port.

Parameters:
UART_BASE, 32'h2000_0000, base address of the UART register block
NCO_VAL, 16'd1208, CTRL.NCO value (115200 baud at 100 MHz)
FIFO_DEPTH, 8, byte FIFO entries; power of two, at least 2
SOURCE_ID, 8'h0, a_source value driven on every request
POLL_GAP, 4, idle cycles between a STATUS read that returned TXFULL=1 and the next poll

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
byte_valid_i  in  1  byte push request
byte_data_i  in  8  byte to transmit
byte_ready_o  out  1  FIFO not full; a push occurs when byte_valid_i and byte_ready_o are both high
busy_o  out  1  high when not in IDLE or when the FIFO is non-empty
init_done_o  out  1  CTRL write acknowledged without error
err_o  out  1  sticky; set by any d_error
sent_cnt_o  out  16  count of acknowledged WDATA writes; wraps at 16'hFFFF->0
tl_a_valid_o  out  1  TL-UL A valid
tl_a_opcode_o  out  3  PutFullData=0, Get=4
tl_a_size_o  out  2  always 2 (4 bytes)
tl_a_source_o  out  8  SOURCE_ID
tl_a_address_o  out  32  request address
tl_a_mask_o  out  4  always 4'hF
tl_a_data_o  out  32  write data; 0 for Get
tl_a_ready_i  in  1  TL-UL A ready
tl_d_valid_i  in  1  TL-UL D valid
tl_d_data_i  in  32  response data
tl_d_error_i  in  1  response error
tl_d_ready_o  out  1  TL-UL D ready

Behaviour:
- Reset: clk is the clock; rst_n is the reset, synchronous and active-low. On reset:
  - state=INIT_REQ
  - FIFO empty, pointers 0
  - all outputs 0, except byte_ready_o=1
  - gap counter 0
- Reset mid-transaction abandons any outstanding request. No D-channel cleanup is required.
- One outstanding transaction at most.
- tl_d_ready_o=1 only in the *_RSP states.
- A-channel fields are registered and stable while tl_a_valid_o=1. tl_a_valid_o deasserts on the cycle after the a_valid&a_ready handshake.
- States:
  - INIT_REQ: drive PutFullData, addr UART_BASE+0x10, data {NCO_VAL,16'h0001}. On handshake go to INIT_RSP.
  - INIT_RSP: on d_valid:
    - if !d_error, set init_done_o=1;
    - if d_error, set err_o=1 and stay out of operation: go to HALT.
    - On success go to IDLE.
  - IDLE: if the FIFO is non-empty go to POLL_REQ.
  - POLL_REQ: Get, addr UART_BASE+0x14. On handshake go to POLL_RSP.
  - POLL_RSP: on d_valid:
    - d_error: set err_o, pop and drop the head byte, go to IDLE.
    - d_data[0]=1 (TXFULL): go to GAP with counter=POLL_GAP.
    - otherwise: go to WR_REQ.
  - GAP: decrement the counter each cycle; at 0 go to POLL_REQ.
  - WR_REQ: PutFullData, addr UART_BASE+0x1c, data {24'h0, FIFO head}. On handshake go to WR_RSP.
  - WR_RSP: on d_valid:
    - pop the head;
    - if !d_error, sent_cnt_o+=1; else set err_o;
    - go to IDLE.
  - HALT: terminal until reset. The FIFO still accepts pushes until full.
- FIFO:
  - Push and pop in the same cycle are both allowed when full or non-empty; occupancy is unchanged.
  - Push when full is ignored (byte_ready_o=0).
  - The head is never popped before its WDATA response arrives.
  - Order is preserved.
- Pointer wrap at FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- d_valid outside *_RSP states is ignored.
- busy_o is registered from the next-state and occupancy values.

Test Plan:
- Release reset, a_ready=1, single-cycle D responses:
  - first request is Put addr 0x2000_0010 data 0x04B8_0001;
  - after its response, init_done_o=1;
  - no further A traffic while the FIFO is empty.
- Push 'H','i' (0x48,0x69):
  - the bus sequence is Get 0x2000_0014, Put 0x2000_001c data 0x48, Get 0x2000_0014, Put 0x2000_001c data 0x69;
  - then sent_cnt_o=2 and busy_o=0.
- STATUS returns 0x1 three times then 0x0:
  - exactly 4 Gets, each separated by at least 4 idle cycles, then one WDATA write;
  - the byte is not lost.
- Hold a_ready=0 for 10 cycles during WR_REQ: address and data are stable for all 10 cycles, and exactly one handshake occurs.
- Push 9 bytes back-to-back while STATUS reports TXFULL: byte_ready_o drops after 8 accepted bytes, and the 9th is not stored. Release TXFULL: exactly 8 writes, in order.
- d_error=1 on the CTRL response: err_o=1, init_done_o=0, no further A requests. rst_n low for 1 cycle mid-poll returns the block to INIT_REQ with the FIFO empty.
